// File: rtl/hmc_int_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM states,
// sequence sources, vector low bytes and the forced BRK opcode.
package hmc_int_pkg;

    typedef enum logic [1:0] {
        RST      = 2'd0,
        RST_WAIT = 2'd1,
        RUN      = 2'd2,
        INJECT   = 2'd3
    } int_state_t;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_IRQ   = 2'd2
    } int_src_t;

    localparam logic [7:0] VEC_NMI_LO = 8'hFA;
    localparam logic [7:0] VEC_RST_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO = 8'hFE;
    localparam logic [7:0] BRK_OPCODE = 8'h00;

    function automatic logic [7:0] src_vector(input int_src_t src);
        logic [7:0] vec;
        case (src)
            SRC_NMI:   vec = VEC_NMI_LO;
            SRC_RESET: vec = VEC_RST_LO;
            default:   vec = VEC_IRQ_LO;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_det.sv
// NMI falling-edge latch: remembers an NMI request until the sequencer
// accepts it; an edge in the acceptance cycle re-arms the latch.
module nmi_edge_det (
    input  logic ph1,
    input  logic reset,
    input  logic nmi_b,
    input  logic accept_nmi,
    output logic nmi_pending
);

    logic r_prev_nmi_b;
    logic r_pending;
    logic w_edge;

    assign w_edge      = r_prev_nmi_b & ~nmi_b;
    assign nmi_pending = r_pending;

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_prev_nmi_b <= 1'b1;
            r_pending    <= 1'b0;
        end else begin
            r_prev_nmi_b <= nmi_b;
            r_pending    <= (r_pending & ~accept_nmi) | w_edge;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Chooses, at each instruction boundary, between the memory opcode and a
// forced BRK for RESET/NMI/IRQ, and supplies vector, B flag and write inhibit.
module interrupt_sequencer
    import hmc_int_pkg::*;
#(
    parameter int RST_CYCLES = 2
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       last_cycle,
    input  logic       nmi_b,
    input  logic       irq_b,
    input  logic       p_i,
    output logic [7:0] opcode_out,
    output logic [7:0] vector_lo,
    output logic       brk_flag,
    output logic       write_inhibit,
    output logic       take_int,
    output logic       nmi_pending
);

    localparam logic [1:0] WAIT_LAST = 2'(RST_CYCLES - 1);

    int_state_t r_state;
    int_state_t w_state_nxt;
    int_src_t   r_src;
    int_src_t   w_src_nxt;
    logic [1:0] r_wait_cnt;
    logic [1:0] w_wait_cnt_nxt;
    logic       w_take_nxt;
    logic       w_accept_nmi;
    logic       w_irq_req;

    logic       r_run;
    logic [7:0] r_vector_lo;
    logic       r_brk_flag;
    logic       r_write_inhibit;
    logic       r_take_int;

    nmi_edge_det u_nmi_edge_det (
        .ph1        (ph1),
        .reset      (reset),
        .nmi_b      (nmi_b),
        .accept_nmi (w_accept_nmi),
        .nmi_pending(nmi_pending)
    );

    assign w_irq_req = ~irq_b & ~p_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_src_nxt      = r_src;
        w_wait_cnt_nxt = r_wait_cnt;
        w_take_nxt     = 1'b0;
        w_accept_nmi   = 1'b0;
        case (r_state)
            RST: begin
                w_state_nxt    = RST_WAIT;
                w_src_nxt      = SRC_RESET;
                w_wait_cnt_nxt = 2'd0;
            end
            RST_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = INJECT;
                    w_src_nxt   = SRC_RESET;
                    w_take_nxt  = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                end
            end
            RUN, INJECT: begin
                // Boundary decision; an unfinished sequence simply stays in INJECT.
                if (last_cycle) begin
                    if (nmi_pending) begin
                        w_state_nxt  = INJECT;
                        w_src_nxt    = SRC_NMI;
                        w_take_nxt   = 1'b1;
                        w_accept_nmi = 1'b1;
                    end else if (w_irq_req) begin
                        w_state_nxt = INJECT;
                        w_src_nxt   = SRC_IRQ;
                        w_take_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: w_state_nxt = RST;
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state         <= RST;
            r_src           <= SRC_RESET;
            r_wait_cnt      <= 2'd0;
            r_run           <= 1'b0;
            r_vector_lo     <= VEC_RST_LO;
            r_brk_flag      <= 1'b0;
            r_write_inhibit <= 1'b1;
            r_take_int      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_src           <= w_src_nxt;
            r_wait_cnt      <= w_wait_cnt_nxt;
            r_run           <= (w_state_nxt == RUN);
            r_vector_lo     <= (w_state_nxt == RUN) ? VEC_IRQ_LO : src_vector(w_src_nxt);
            r_brk_flag      <= (w_state_nxt == RUN);
            r_write_inhibit <= (w_state_nxt == RST) || (w_state_nxt == RST_WAIT) ||
                               ((w_state_nxt == INJECT) && (w_src_nxt == SRC_RESET));
            r_take_int      <= w_take_nxt;
        end
    end

    // Memory opcode passes straight through in RUN so the FSM latches it unregistered.
    assign opcode_out    = r_run ? data_in : BRK_OPCODE;
    assign vector_lo     = r_vector_lo;
    assign brk_flag      = r_brk_flag;
    assign write_inhibit = r_write_inhibit;
    assign take_int      = r_take_int;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed scenarios plus randomized traffic, every output compared each
// cycle against a boot-countdown / sequence-tag model of the sequencer.
module tb_interrupt_sequencer;

    localparam int RST_CYCLES = 2;
    localparam int SEQ_NONE = 0;
    localparam int SEQ_RESET = 1;
    localparam int SEQ_NMI = 2;
    localparam int SEQ_IRQ = 3;

    logic       ph1 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       last_cycle = 1'b0;
    logic       nmi_b = 1'b1;
    logic       irq_b = 1'b1;
    logic       p_i = 1'b1;
    logic [7:0] opcode_out;
    logic [7:0] vector_lo;
    logic       brk_flag;
    logic       write_inhibit;
    logic       take_int;
    logic       nmi_pending;

    int n_vec = 0;
    int n_err = 0;

    int m_boot_left;
    int m_seq;
    bit m_pend;
    bit m_prev_nmi_b;
    bit m_take;

    interrupt_sequencer #(.RST_CYCLES(RST_CYCLES)) dut (
        .ph1          (ph1),
        .reset        (reset),
        .data_in      (data_in),
        .last_cycle   (last_cycle),
        .nmi_b        (nmi_b),
        .irq_b        (irq_b),
        .p_i          (p_i),
        .opcode_out   (opcode_out),
        .vector_lo    (vector_lo),
        .brk_flag     (brk_flag),
        .write_inhibit(write_inhibit),
        .take_int     (take_int),
        .nmi_pending  (nmi_pending)
    );

    always #5 ph1 = ~ph1;

    task automatic expect_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, obs, exp);
        end
    endtask

    // Model advance on a clock edge, from the currently held inputs.
    task automatic model_edge();
        bit nmi_fall;
        bit accepted;
        nmi_fall = m_prev_nmi_b && !nmi_b;
        accepted = 1'b0;
        m_take   = 1'b0;
        if (reset) begin
            m_boot_left  = RST_CYCLES + 1;
            m_seq        = SEQ_NONE;
            m_pend       = 1'b0;
            m_prev_nmi_b = 1'b1;
        end else begin
            if (m_boot_left > 0) begin
                m_boot_left--;
                if (m_boot_left == 0) begin
                    m_seq  = SEQ_RESET;
                    m_take = 1'b1;
                end
            end else if (last_cycle) begin
                if (m_pend) begin
                    m_seq    = SEQ_NMI;
                    m_take   = 1'b1;
                    accepted = 1'b1;
                end else if (!irq_b && !p_i) begin
                    m_seq  = SEQ_IRQ;
                    m_take = 1'b1;
                end else begin
                    m_seq = SEQ_NONE;
                end
            end
            m_pend       = (m_pend && !accepted) || nmi_fall;
            m_prev_nmi_b = nmi_b;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_op, e_vec;
        logic       e_brk, e_wi;
        if (m_boot_left > 0) begin
            e_op = 8'h00; e_vec = 8'hFC; e_brk = 1'b0; e_wi = 1'b1;
        end else if (m_seq == SEQ_NONE) begin
            e_op = data_in; e_vec = 8'hFE; e_brk = 1'b1; e_wi = 1'b0;
        end else begin
            e_op  = 8'h00;
            e_vec = (m_seq == SEQ_NMI) ? 8'hFA : (m_seq == SEQ_RESET) ? 8'hFC : 8'hFE;
            e_brk = 1'b0;
            e_wi  = (m_seq == SEQ_RESET);
        end
        expect_eq("opcode_out", opcode_out, e_op);
        expect_eq("vector_lo", vector_lo, e_vec);
        expect_eq("brk_flag", {7'd0, brk_flag}, {7'd0, e_brk});
        expect_eq("write_inhibit", {7'd0, write_inhibit}, {7'd0, e_wi});
        expect_eq("take_int", {7'd0, take_int}, {7'd0, m_take});
        expect_eq("nmi_pending", {7'd0, nmi_pending}, {7'd0, m_pend});
    endtask

    task automatic tick(input logic r, input logic lc, input logic nb, input logic ib,
                        input logic pi, input logic [7:0] d);
        reset = r; last_cycle = lc; nmi_b = nb; irq_b = ib; p_i = pi; data_in = d;
        @(posedge ph1);
        model_edge();
        @(negedge ph1);
        check_outputs();
    endtask

    initial begin
        logic r_v, lc_v, nb_v, ib_v, pi_v;
        m_boot_left = RST_CYCLES + 1; m_seq = SEQ_NONE; m_pend = 0; m_prev_nmi_b = 1; m_take = 0;

        // Reset held 3 cycles, boot countdown, RESET injection, then finish it.
        repeat (3) tick(1, 0, 1, 1, 1, 8'h00);
        repeat (5) tick(0, 0, 1, 1, 1, 8'h00);
        tick(0, 1, 1, 1, 1, 8'h00);

        // Plain execution, ten boundaries, no requests.
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 1, 1, 1, 8'h69);
            tick(0, 1, 1, 1, 1, 8'h69);
        end

        // Masked IRQ stays in RUN; unmasked IRQ is taken; finish with I set.
        tick(0, 1, 1, 0, 1, 8'h69);
        tick(0, 0, 1, 0, 1, 8'h4C);
        tick(0, 1, 1, 0, 0, 8'h4C);
        repeat (3) tick(0, 0, 1, 0, 1, 8'hEA);
        tick(0, 1, 1, 0, 1, 8'hEA);
        tick(0, 0, 1, 1, 1, 8'hEA);

        // NMI with IRQ also pending: NMI first, then IRQ back-to-back.
        tick(0, 0, 0, 0, 0, 8'hA9);
        tick(0, 1, 0, 0, 0, 8'hA9);
        repeat (3) tick(0, 0, 0, 0, 0, 8'h00);
        tick(0, 1, 1, 0, 0, 8'h00);
        repeat (2) tick(0, 0, 1, 1, 1, 8'h00);
        tick(0, 1, 1, 1, 1, 8'h00);

        // NMI held low 20 cycles: a single service.
        for (int i = 0; i < 20; i++) tick(0, (i % 4) == 3, 0, 1, 1, 8'h18);
        tick(0, 1, 1, 1, 1, 8'h18);
        // Second edge exactly in the acceptance cycle: pending survives.
        tick(0, 0, 0, 1, 1, 8'h18);
        tick(0, 0, 1, 1, 1, 8'h18);
        tick(0, 1, 0, 1, 1, 8'h18);
        tick(0, 0, 0, 1, 1, 8'h18);
        tick(0, 1, 1, 1, 1, 8'h18);
        tick(0, 1, 1, 1, 1, 8'h18);

        // Reset mid-INJECT with another NMI pending.
        tick(0, 0, 0, 1, 1, 8'h38);
        tick(0, 1, 1, 1, 1, 8'h38);
        tick(0, 0, 0, 1, 1, 8'h38);
        tick(1, 1, 1, 1, 1, 8'h38);
        repeat (4) tick(0, 0, 1, 1, 1, 8'h38);
        tick(0, 1, 1, 1, 1, 8'h38);

        // Randomized traffic.
        nb_v = 1'b1; ib_v = 1'b1; pi_v = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r_v  = ($urandom_range(0, 199) == 0);
            lc_v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) nb_v = ~nb_v;
            if ($urandom_range(0, 7) == 0) ib_v = ~ib_v;
            if ($urandom_range(0, 5) == 0) pi_v = ~pi_v;
            tick(r_v, lc_v, nb_v, ib_v, pi_v, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
